// File: rtl/io_tx_buffer.sv
// io_tx_buffer: captures CPU byte writes to the UART and stop ports, queues them in a
// first-word fall-through FIFO drained over valid/ready, and sequences the 0x00 stop terminator.
module io_tx_buffer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int FULL_MARGIN = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic [31:0]         mem_a,
  input  logic [7:0]          mem_dout,
  input  logic                mem_wr,
  output logic                io_buffer_full,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic                sim_done
);

  localparam int DEPTH        = 1 << DEPTH_LOG2;
  localparam int FULL_LEVEL_I = DEPTH - FULL_MARGIN;

  localparam logic [DEPTH_LOG2:0]   DEPTH_C    = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = FULL_LEVEL_I[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                state_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  full_q;
  logic                  overflow_q;
  logic                  done_q;
  logic                  term_pend_q;

  logic       io_hit;
  logic       data_wr;
  logic       stop_wr;
  logic       pop;
  logic       can_push;
  logic       push;
  logic       drop;
  logic [7:0] push_data;
  logic       unused_addr;

  assign io_hit   = rdy_in && mem_wr && (mem_a[17:16] == 2'b11);
  assign data_wr  = io_hit && !mem_a[2];
  assign stop_wr  = io_hit && mem_a[2];
  assign pop      = tx_valid && tx_ready;
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign can_push = (count_q != DEPTH_C) || pop;

  assign unused_addr = ^{mem_a[31:18], mem_a[15:3], mem_a[1:0]};

  always_comb begin
    push      = 1'b0;
    push_data = 8'h00;
    drop      = 1'b0;
    case (state_q)
      RUN: begin
        if (data_wr && (mem_dout != 8'h00)) begin
          if (can_push) begin
            push      = 1'b1;
            push_data = mem_dout;
          end else begin
            drop = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (term_pend_q && can_push) begin
          push = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      term_pend_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      full_q  <= (count_d >= FULL_LEVEL);
      if (drop) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        RUN: begin
          if (stop_wr) begin
            term_pend_q <= 1'b1;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (term_pend_q) begin
            if (can_push) begin
              term_pend_q <= 1'b0;
            end
          end else if ((count_q == '0) && !pop) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  // Storage needs no reset: tx_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign tx_valid       = (count_q != '0);
  assign tx_data        = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign count          = count_q;
  assign io_buffer_full = full_q;
  assign overflow       = overflow_q;
  assign sim_done       = done_q;

endmodule
